// File: rtl/ct_ciu_respq_pkg.sv
// Shared definitions for the CIU CTC response queue: responder bit indices and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ct_ciu_respq_pkg;

    // Bit position of each responder inside every completion vector.
    localparam int RESPQ_PIU0 = 0;
    localparam int RESPQ_PIU1 = 1;
    localparam int RESPQ_PIU2 = 2;
    localparam int RESPQ_PIU3 = 3;
    localparam int RESPQ_EBIU = 4;
    localparam int RESPQ_L2C  = 5;

    localparam int RESPQ_NUM_RESP = 6;
    localparam int RESPQ_DEPTH    = 4;

    // Slot index increment with wrap at depth-1, valid for any depth (not only powers of two).
    function automatic int respq_ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ct_ciu_respq_slot.sv
// One response-queue slot: valid, per-responder completion bits and DVM flag.
// Latency: create/response/pop take effect at the next respqentyclk edge; all_cmplt is combinational.
// Backpressure: none; the owner guarantees create and pop never target this slot in the same cycle.
//
// Ports: respqentyclk/cpurst_b clock and async active-low reset; create/create_cmplt/create_dvm
// load the slot; set_bits marks responders done (only while valid); pop clears the slot;
// vld/all_cmplt/dvm report the slot state.
module ct_ciu_respq_slot
    import ct_ciu_respq_pkg::*;
#(
    parameter int NUM_RESP = RESPQ_NUM_RESP
) (
    input  logic                respqentyclk,
    input  logic                cpurst_b,
    input  logic                create,
    input  logic [NUM_RESP-1:0] create_cmplt,
    input  logic                create_dvm,
    input  logic [NUM_RESP-1:0] set_bits,
    input  logic                pop,
    output logic                vld,
    output logic                all_cmplt,
    output logic                dvm
);

    logic [NUM_RESP-1:0] cmplt;

    always_ff @(posedge respqentyclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld   <= 1'b0;
            cmplt <= '0;
            dvm   <= 1'b0;
        end else if (pop) begin
            vld   <= 1'b0;
            cmplt <= '0;
            dvm   <= 1'b0;
        end else if (create) begin
            vld   <= 1'b1;
            cmplt <= create_cmplt;
            dvm   <= create_dvm;
        end else if (vld) begin
            // Responses to an empty slot are dropped; repeats are harmless ORs.
            cmplt <= cmplt | set_bits;
        end
    end

    assign all_cmplt = &cmplt;

endmodule

// File: rtl/ct_ciu_ctcq_respq_fifo.sv
// In-order CTC response queue: DEPTH slots allocated at tail, retired from head when all responders completed.
// Latency: create/response visible next cycle; pop_vld/pop_ptr/pop_dvm combinational from registers.
// Backpressure: create_rdy low when full (no flow-through on create+pop); head held until pop_rdy.
//
// Ports: respq_create_* allocate the tail slot; respq_resp_vld/respq_resp_ptr carry one completion
// pulse and slot index per responder; respq_pop_* is the head valid/ready handshake; respq_vld,
// respq_dvm, respq_empty expose queue state; respq_timeout_err is the sticky head-stall flag.
// Optional feature: define CT_CIU_RESPQ_TIMEOUT_EN to build the head-of-queue watchdog (TO_W bits).
module ct_ciu_ctcq_respq_fifo
    import ct_ciu_respq_pkg::*;
#(
    parameter int DEPTH    = RESPQ_DEPTH,
    parameter int NUM_RESP = RESPQ_NUM_RESP,
    parameter int PTR_W    = 2,
    parameter int TO_W     = 10
) (
    input  logic                      respqentyclk,
    input  logic                      cpurst_b,
    input  logic                      respq_create_en,
    input  logic [NUM_RESP-1:0]       respq_create_cmplt_init,
    input  logic                      respq_create_dvm,
    output logic                      respq_create_rdy,
    output logic [PTR_W-1:0]          respq_create_ptr,
    input  logic [NUM_RESP-1:0]       respq_resp_vld,
    input  logic [NUM_RESP*PTR_W-1:0] respq_resp_ptr,
    output logic                      respq_pop_vld,
    output logic [PTR_W-1:0]          respq_pop_ptr,
    output logic                      respq_pop_dvm,
    input  logic                      respq_pop_rdy,
    output logic [DEPTH-1:0]          respq_vld,
    output logic [DEPTH-1:0]          respq_dvm,
    output logic                      respq_empty,
    output logic                      respq_timeout_err
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]    head_ptr;
    logic [PTR_W-1:0]    tail_ptr;
    logic [PTR_W:0]      entry_cnt;
    logic                create_fire;
    logic                pop_fire;
    logic [DEPTH-1:0]    slot_create;
    logic [DEPTH-1:0]    slot_pop;
    logic [DEPTH-1:0]    slot_all_cmplt;
    logic [NUM_RESP-1:0] slot_set [DEPTH];

    assign respq_create_rdy = (entry_cnt != CNT_FULL);
    assign respq_empty      = (entry_cnt == '0);
    assign respq_create_ptr = tail_ptr;
    assign respq_pop_ptr    = head_ptr;
    assign respq_pop_vld    = respq_vld[head_ptr] & slot_all_cmplt[head_ptr];
    assign respq_pop_dvm    = respq_dvm[head_ptr];

    assign create_fire = respq_create_en & respq_create_rdy;
    assign pop_fire    = respq_pop_vld & respq_pop_rdy;

    // Steer create/pop to one slot each and fan each responder's pulse to the slot it names.
    always_comb begin
        slot_create = '0;
        slot_pop    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_set[i]    = '0;
            slot_create[i] = create_fire && (tail_ptr == PTR_W'(i));
            slot_pop[i]    = pop_fire && (head_ptr == PTR_W'(i));
            for (int k = 0; k < NUM_RESP; k++) begin
                slot_set[i][k] = respq_resp_vld[k] && (respq_resp_ptr[k*PTR_W +: PTR_W] == PTR_W'(i));
            end
        end
    end

    always_ff @(posedge respqentyclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            entry_cnt <= '0;
        end else begin
            if (create_fire) begin
                tail_ptr <= PTR_W'(respq_ptr_inc(int'(tail_ptr), DEPTH));
            end
            if (pop_fire) begin
                head_ptr <= PTR_W'(respq_ptr_inc(int'(head_ptr), DEPTH));
            end
            case ({create_fire, pop_fire})
                2'b10:   entry_cnt <= entry_cnt + 1'b1;
                2'b01:   entry_cnt <= entry_cnt - 1'b1;
                default: entry_cnt <= entry_cnt;
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        ct_ciu_respq_slot #(
            .NUM_RESP (NUM_RESP)
        ) u_slot (
            .respqentyclk (respqentyclk),
            .cpurst_b     (cpurst_b),
            .create       (slot_create[i]),
            .create_cmplt (respq_create_cmplt_init),
            .create_dvm   (respq_create_dvm),
            .set_bits     (slot_set[i]),
            .pop          (slot_pop[i]),
            .vld          (respq_vld[i]),
            .all_cmplt    (slot_all_cmplt[i]),
            .dvm          (respq_dvm[i])
        );
    end

`ifdef CT_CIU_RESPQ_TIMEOUT_EN
    // Counts cycles a valid head waits for responses; saturates, and the error latches until reset.
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;
    logic            to_err;

    always_comb begin
        to_cnt_nxt = to_cnt;
        if (respq_empty || pop_fire) begin
            to_cnt_nxt = '0;
        end else if (respq_vld[head_ptr] && !respq_pop_vld && (to_cnt != '1)) begin
            to_cnt_nxt = to_cnt + 1'b1;
        end
    end

    always_ff @(posedge respqentyclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            to_cnt <= to_cnt_nxt;
            to_err <= to_err | (&to_cnt_nxt);
        end
    end

    assign respq_timeout_err = to_err;
`else
    assign respq_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ct_ciu_ctcq_respq_fifo.sv
// Self-checking bench for ct_ciu_ctcq_respq_fifo: directed scenarios plus randomized traffic vs a slot-array model.
// Latency: model updated at each rising edge, outputs compared 1 time unit later.
// Backpressure: pop_rdy randomized; creates only issued when the model says space exists (except one directed case).
module tb_ct_ciu_ctcq_respq_fifo;

    localparam int DEPTH    = 4;
    localparam int NUM_RESP = 6;
    localparam int PTR_W    = 2;
`ifdef CT_CIU_RESPQ_TIMEOUT_EN
    localparam int TO_W     = 4;
`else
    localparam int TO_W     = 10;
`endif
    localparam int TO_MAX   = (1 << TO_W) - 1;

    logic                      clk;
    logic                      cpurst_b;
    logic                      respq_create_en;
    logic [NUM_RESP-1:0]       respq_create_cmplt_init;
    logic                      respq_create_dvm;
    logic                      respq_create_rdy;
    logic [PTR_W-1:0]          respq_create_ptr;
    logic [NUM_RESP-1:0]       respq_resp_vld;
    logic [NUM_RESP*PTR_W-1:0] respq_resp_ptr;
    logic                      respq_pop_vld;
    logic [PTR_W-1:0]          respq_pop_ptr;
    logic                      respq_pop_dvm;
    logic                      respq_pop_rdy;
    logic [DEPTH-1:0]          respq_vld;
    logic [DEPTH-1:0]          respq_dvm;
    logic                      respq_empty;
    logic                      respq_timeout_err;

    ct_ciu_ctcq_respq_fifo #(
        .DEPTH    (DEPTH),
        .NUM_RESP (NUM_RESP),
        .PTR_W    (PTR_W),
        .TO_W     (TO_W)
    ) u_dut (
        .respqentyclk            (clk),
        .cpurst_b                (cpurst_b),
        .respq_create_en         (respq_create_en),
        .respq_create_cmplt_init (respq_create_cmplt_init),
        .respq_create_dvm        (respq_create_dvm),
        .respq_create_rdy        (respq_create_rdy),
        .respq_create_ptr        (respq_create_ptr),
        .respq_resp_vld          (respq_resp_vld),
        .respq_resp_ptr          (respq_resp_ptr),
        .respq_pop_vld           (respq_pop_vld),
        .respq_pop_ptr           (respq_pop_ptr),
        .respq_pop_dvm           (respq_pop_dvm),
        .respq_pop_rdy           (respq_pop_rdy),
        .respq_vld               (respq_vld),
        .respq_dvm               (respq_dvm),
        .respq_empty             (respq_empty),
        .respq_timeout_err       (respq_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a circular array of slots with head index and occupancy.
    bit                  m_vld   [DEPTH];
    logic [NUM_RESP-1:0] m_cmplt [DEPTH];
    bit                  m_dvm   [DEPTH];
    int                  m_head;
    int                  m_cnt;
    int                  m_to;
    bit                  m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_pop_vld();
        return m_vld[m_head] && (m_cmplt[m_head] == {NUM_RESP{1'b1}});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i]   = 1'b0;
            m_cmplt[i] = '0;
            m_dvm[i]   = 1'b0;
        end
        m_head = 0;
        m_cnt  = 0;
        m_to   = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [DEPTH-1:0] ev;
        logic [DEPTH-1:0] ed;
        for (int i = 0; i < DEPTH; i++) begin
            ev[i] = m_vld[i];
            ed[i] = m_dvm[i];
        end
        chk("create_rdy", 32'(respq_create_rdy), 32'(m_cnt < DEPTH));
        chk("create_ptr", 32'(respq_create_ptr), 32'((m_head + m_cnt) % DEPTH));
        chk("empty",      32'(respq_empty),      32'(m_cnt == 0));
        chk("pop_vld",    32'(respq_pop_vld),    32'(m_pop_vld()));
        chk("pop_ptr",    32'(respq_pop_ptr),    32'(m_head));
        chk("pop_dvm",    32'(respq_pop_dvm),    32'(m_dvm[m_head]));
        chk("vld_vec",    32'(respq_vld),        32'(ev));
        chk("dvm_vec",    32'(respq_dvm),        32'(ed));
        chk("timeout",    32'(respq_timeout_err), 32'(m_err));
    endtask

    task automatic idle_inputs();
        respq_create_en         = 1'b0;
        respq_create_cmplt_init = '0;
        respq_create_dvm        = 1'b0;
        respq_resp_vld          = '0;
        respq_resp_ptr          = '0;
        respq_pop_rdy           = 1'b0;
    endtask

    // Advance one clock: the model consumes the inputs present at the edge, then outputs are compared.
    task automatic cycle();
        bit pv;
        bit cf;
        bit pf;
        int tl;
        int hd;
        int p;
        pv = m_pop_vld();
        cf = respq_create_en && (m_cnt < DEPTH);
        pf = pv && respq_pop_rdy;
        tl = (m_head + m_cnt) % DEPTH;
        hd = m_head;
        @(posedge clk);
`ifdef CT_CIU_RESPQ_TIMEOUT_EN
        if (m_cnt == 0 || pf) m_to = 0;
        else if (!pv && m_to < TO_MAX) m_to++;
        if (m_to == TO_MAX) m_err = 1'b1;
`endif
        for (int k = 0; k < NUM_RESP; k++) begin
            if (respq_resp_vld[k]) begin
                p = int'(respq_resp_ptr[k*PTR_W +: PTR_W]);
                if (m_vld[p]) m_cmplt[p][k] = 1'b1;
            end
        end
        if (pf) begin
            m_vld[hd]   = 1'b0;
            m_cmplt[hd] = '0;
            m_dvm[hd]   = 1'b0;
            m_head      = (hd + 1) % DEPTH;
        end
        if (cf) begin
            m_vld[tl]   = 1'b1;
            m_cmplt[tl] = respq_create_cmplt_init;
            m_dvm[tl]   = respq_create_dvm;
        end
        m_cnt = m_cnt + int'(cf) - int'(pf);
        #1;
        check_outputs();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        cpurst_b = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        cpurst_b = 1'b1;
    endtask

    task automatic resp_all(input int slot);
        respq_resp_vld = '1;
        for (int k = 0; k < NUM_RESP; k++) respq_resp_ptr[k*PTR_W +: PTR_W] = PTR_W'(slot);
    endtask

    task automatic create(input logic [NUM_RESP-1:0] init, input logic dvm);
        respq_create_en         = 1'b1;
        respq_create_cmplt_init = init;
        respq_create_dvm        = dvm;
    endtask

    initial begin
        cpurst_b = 1'b1;
        idle_inputs();
        #2;

        // Reset and idle
        do_reset();
        chk("rst_create_rdy", 32'(respq_create_rdy), 32'd1);
        chk("rst_empty",      32'(respq_empty),      32'd1);
        chk("rst_pop_vld",    32'(respq_pop_vld),    32'd0);
        chk("rst_vld",        32'(respq_vld),        32'd0);
        chk("rst_timeout",    32'(respq_timeout_err), 32'd0);
        cycle();

        // Single pre-completed DVM entry, then pop
        create('1, 1'b1); cycle();
        chk("one_pop_vld", 32'(respq_pop_vld), 32'd1);
        chk("one_pop_ptr", 32'(respq_pop_ptr), 32'd0);
        chk("one_pop_dvm", 32'(respq_pop_dvm), 32'd1);
        respq_pop_rdy = 1'b1; cycle();
        chk("one_empty", 32'(respq_empty), 32'd1);

        // Fill, reject fifth create, out-of-order completion
        do_reset();
        repeat (4) begin create('0, 1'b0); cycle(); end
        chk("full_rdy", 32'(respq_create_rdy), 32'd0);
        create('1, 1'b1); cycle();
        chk("full_vld", 32'(respq_vld), 32'hF);
        chk("full_dvm", 32'(respq_dvm), 32'h0);
        resp_all(2); cycle();
        chk("slot2_done_pop_vld", 32'(respq_pop_vld), 32'd0);
        resp_all(0); cycle();
        chk("slot0_done_pop_vld", 32'(respq_pop_vld), 32'd1);
        chk("slot0_done_pop_ptr", 32'(respq_pop_ptr), 32'd0);
        // Create while full with pop: create refused, count drops to 3
        create('1, 1'b0); respq_pop_rdy = 1'b1; cycle();
        chk("full_cp_vld", 32'(respq_vld), 32'hE);

        // Multi-responder hit, response to invalid slot, response racing a create
        do_reset();
        create('0, 1'b0); cycle();
        create('0, 1'b1); cycle();
        resp_all(1); cycle();
        resp_all(3); cycle();
        create('0, 1'b0); resp_all(2); cycle();
        create('0, 1'b1); cycle();
        resp_all(0); cycle();
        respq_pop_rdy = 1'b1; cycle();
        chk("slot1_pop_vld", 32'(respq_pop_vld), 32'd1);
        chk("slot1_pop_ptr", 32'(respq_pop_ptr), 32'd1);
        chk("slot1_pop_dvm", 32'(respq_pop_dvm), 32'd1);
        respq_pop_rdy = 1'b1; cycle();
        chk("slot2_race_pop_vld", 32'(respq_pop_vld), 32'd0);
        resp_all(2); cycle();
        respq_pop_rdy = 1'b1; cycle();
        chk("slot3_pop_ptr", 32'(respq_pop_ptr), 32'd3);
        chk("slot3_pop_vld", 32'(respq_pop_vld), 32'd0);

        // Wrap with simultaneous create and pop at count 1
        do_reset();
        create('1, 1'b0); cycle();
        repeat (6) begin create('1, 1'b0); respq_pop_rdy = 1'b1; cycle(); end
        chk("wrap_pop_ptr",    32'(respq_pop_ptr),    32'd2);
        chk("wrap_create_ptr", 32'(respq_create_ptr), 32'd3);
        chk("wrap_vld",        32'(respq_vld),        32'h4);

`ifdef CT_CIU_RESPQ_TIMEOUT_EN
        // Head stall drives the watchdog to saturation
        do_reset();
        create('0, 1'b0); cycle();
        repeat (TO_MAX - 1) cycle();
        chk("to_before", 32'(respq_timeout_err), 32'd0);
        cycle();
        chk("to_set", 32'(respq_timeout_err), 32'd1);
        resp_all(0); cycle();
        respq_pop_rdy = 1'b1; cycle();
        chk("to_sticky", 32'(respq_timeout_err), 32'd1);
        do_reset();
        chk("to_cleared", 32'(respq_timeout_err), 32'd0);
`endif

        // Randomized traffic with a mid-run asynchronous reset
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                cpurst_b = 1'b0;
                #1;
                model_reset();
                check_outputs();
                #2;
                cpurst_b = 1'b1;
            end
            if (m_cnt < DEPTH && ($urandom_range(0, 3) != 0)) begin
                create(NUM_RESP'($urandom) | NUM_RESP'($urandom) | NUM_RESP'($urandom),
                       1'($urandom));
            end
            respq_resp_vld = NUM_RESP'($urandom & $urandom);
            respq_resp_ptr = (NUM_RESP*PTR_W)'($urandom);
            respq_pop_rdy  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
